// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC owner, single-outstanding imem requester, IF/ID presenter
// Redirects from EX retarget the PC and kill any fetch already in flight.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] out_pc_r, out_pc_nx;
  logic [31:0] out_inst_r, out_inst_nx;
  logic        kill, kill_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      out_pc_r   <= 32'h0;
      out_inst_r <= 32'h0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      kill       <= kill_nx;
      out_pc_r   <= out_pc_nx;
      out_inst_r <= out_inst_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    kill_nx     = kill;
    out_pc_nx   = out_pc_r;
    out_inst_nx = out_inst_r;
    case (state)
      S_REQ: begin
        if (imem_gnt) begin
          state_nx = S_WAIT;
          if (redirect) kill_nx = 1'b1;
        end
      end
      S_WAIT: begin
        // A redirect arriving with the response makes that response stale too.
        if (imem_rvalid) begin
          if (kill || redirect) begin
            kill_nx  = 1'b0;
            state_nx = S_REQ;
          end else begin
            out_inst_nx = imem_rdata;
            out_pc_nx   = pc;
            state_nx    = S_HOLD;
          end
        end else if (redirect) begin
          kill_nx = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_nx = S_REQ;
        end else if (out_ready) begin
          pc_nx    = pc + 32'd4;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
    if (redirect) pc_nx = redirect_pc;
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign out_valid = (state == S_HOLD);
  assign out_pc    = out_pc_r;
  assign out_inst  = out_inst_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_checks = 0;
  int n_pass   = 0;

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From S_REQ at exp_pc: grant now, return data k cycles later, land in S_HOLD.
  task automatic fetch_to_hold(input logic [31:0] exp_pc, input int k);
    check("req_high", imem_req, 1);
    check("req_addr", imem_addr, exp_pc);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_req_low", imem_req, 0);
    check("wait_valid_low", out_valid, 0);
    repeat (k - 1) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(exp_pc);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("hold_valid", out_valid, 1);
    check("hold_pc", out_pc, exp_pc);
    check("hold_inst", out_inst, mem_word(exp_pc));
  endtask

  // From S_HOLD: stall 'delay' cycles, then accept.
  task automatic accept(input int delay);
    logic [31:0] pc_q, inst_q;
    pc_q   = out_pc;
    inst_q = out_inst;
    for (int i = 0; i < delay; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_req_low", imem_req, 0);
      check("stall_pc", out_pc, pc_q);
      check("stall_inst", out_inst, inst_q);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("acc_valid_low", out_valid, 0);
    check("acc_pc_kept", out_pc, pc_q);
    check("acc_next_addr", imem_addr, pc_q + 32'd4);
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    out_ready   = 1'b0;

    // 1: reset, then three back-to-back fetches
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_req", imem_req, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_addr", imem_addr, 32'h8000_0000);
    fetch_to_hold(32'h8000_0000, 1); accept(0);
    fetch_to_hold(32'h8000_0004, 1); accept(0);
    fetch_to_hold(32'h8000_0008, 1); accept(0);

    // 2: five-cycle stall in S_HOLD
    fetch_to_hold(32'h8000_000C, 2); accept(5);

    // 3: redirect during S_WAIT, stale response three cycles later
    check("t3_addr", imem_addr, 32'h8000_0010);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect = 1'b0;
    check("t3_wait_req", imem_req, 0);
    tick();
    check("t3_valid_a", out_valid, 0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h8000_0010);
    tick();
    imem_rvalid = 1'b0;
    check("t3_dropped", out_valid, 0);
    check("t3_req", imem_req, 1);
    check("t3_addr_new", imem_addr, 32'h8000_0100);
    tick();
    check("t3_still_dropped", out_valid, 0);

    // 4: redirect in S_HOLD with out_ready=1
    fetch_to_hold(32'h8000_0100, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0200;
    out_ready   = 1'b1;
    tick();
    redirect  = 1'b0;
    out_ready = 1'b0;
    check("t4_valid", out_valid, 0);
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h8000_0200);

    // 5: redirect with gnt, second redirect before rvalid
    imem_gnt    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0300;
    tick();
    imem_gnt    = 1'b0;
    redirect_pc = 32'h8000_0400;
    tick();
    redirect = 1'b0;
    check("t5_wait_req", imem_req, 0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h8000_0200);
    tick();
    imem_rvalid = 1'b0;
    check("t5_dropped", out_valid, 0);
    check("t5_addr", imem_addr, 32'h8000_0400);
    fetch_to_hold(32'h8000_0400, 1); accept(0);

    // 6: PC wrap, then reset in S_WAIT with a stale response afterwards
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    fetch_to_hold(32'hFFFF_FFFC, 1); accept(0);
    check("t6_wrap", imem_addr, 32'h0000_0000);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_req", imem_req, 1);
    check("t6_rst_addr", imem_addr, 32'h8000_0000);
    check("t6_rst_out_pc", out_pc, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h0000_0000);
    tick();
    imem_rvalid = 1'b0;
    check("t6_stale_valid", out_valid, 0);
    check("t6_stale_addr", imem_addr, 32'h8000_0000);
    fetch_to_hold(32'h8000_0000, 1); accept(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
